// File: rtl/aes_session_controller_if.sv
// Handshake bundle between the AES session sequencer and the serial RX/TX units and crypto engines.
// The controller connects through the slave modport; the environment driving it uses the master modport.
interface aes_session_controller_if #(
    parameter int BLK_W = 8
);
    logic             ProgramSelector;
    logic [BLK_W-1:0] NumBlocks;
    logic             KeyNew;
    logic             SerialReadRy;
    logic             SerialKeyRy;
    logic             KeyRy;
    logic             EncRy;
    logic             DecRy;
    logic             OutRy;
    logic             SerialWriteRy;

    logic             SerialReadEn;
    logic             KeyEn;
    logic             EncEn;
    logic             DecEn;
    logic             OutEn;
    logic             SerialWriteEn;
    logic             RstKey;
    logic             RstEncryptor;
    logic             ProgramRunning;
    logic [BLK_W-1:0] BlkIdx;
    logic             Done;
    logic             Error;

    modport master (
        output ProgramSelector, NumBlocks, KeyNew, SerialReadRy, SerialKeyRy,
               KeyRy, EncRy, DecRy, OutRy, SerialWriteRy,
        input  SerialReadEn, KeyEn, EncEn, DecEn, OutEn, SerialWriteEn,
               RstKey, RstEncryptor, ProgramRunning, BlkIdx, Done, Error
    );

    modport slave (
        input  ProgramSelector, NumBlocks, KeyNew, SerialReadRy, SerialKeyRy,
               KeyRy, EncRy, DecRy, OutRy, SerialWriteRy,
        output SerialReadEn, KeyEn, EncEn, DecEn, OutEn, SerialWriteEn,
               RstKey, RstEncryptor, ProgramRunning, BlkIdx, Done, Error
    );
endinterface

// File: rtl/aes_session_controller.sv
// AES session sequencer: one key expansion per session (skipped while the key stays valid), then
// read -> encrypt/decrypt -> output -> write per block. Define AES_CTRL_TIMEOUT_EN for the watchdog/ERR state.
module aes_session_controller #(
    parameter int BLK_W      = 8,
    parameter int TMO_W      = 16,
    parameter int TMO_CYCLES = 50000
) (
    input logic                     Clk,
    input logic                     Rst,
    aes_session_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        KEY   = 3'd2,
        ENC   = 3'd3,
        DEC   = 3'd4,
        OUT   = 3'd5,
        WRITE = 3'd6,
        ERR   = 3'd7
    } state_e;

    if (TMO_CYCLES < 1 || TMO_CYCLES >= (2 ** TMO_W)) begin : gBadTmoCycles
        $error("TMO_CYCLES must lie in [1, 2**TMO_W)");
    end

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [BLK_W-1:0] total_q, total_d;
    logic [BLK_W-1:0] blkIdx_q, blkIdx_d;
    logic             keyValid_q, keyValid_d;
    logic             running_q, running_d;
    logic             rstKey_q, rstKey_d;
    logic             rstEnc_q, rstEnc_d;
    logic             done_q, done_d;
    logic [5:0]       en_q, en_d;
`ifdef AES_CTRL_TIMEOUT_EN
    logic             error_q, error_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        total_d    = total_q;
        blkIdx_d   = blkIdx_q;
        keyValid_d = keyValid_q;
        running_d  = running_q;
        rstKey_d   = 1'b0;
        rstEnc_d   = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                state_d  = READ;
                blkIdx_d = '0;
                mode_d   = bus.ProgramSelector;
                total_d  = (bus.NumBlocks == '0) ? BLK_W'(1) : bus.NumBlocks;
            end
            // The key-ready qualifier only matters for the first block of a session.
            READ: begin
                if (bus.SerialReadRy && (blkIdx_q != '0 || bus.SerialKeyRy)) begin
                    running_d = 1'b1;
                    if (blkIdx_q == '0 && (bus.KeyNew || !keyValid_q)) begin
                        state_d  = KEY;
                        rstKey_d = 1'b1;
                    end else begin
                        state_d  = mode_q ? ENC : DEC;
                        rstEnc_d = 1'b1;
                    end
                end
            end
            KEY: begin
                if (bus.KeyRy) begin
                    keyValid_d = 1'b1;
                    state_d    = mode_q ? ENC : DEC;
                    rstEnc_d   = 1'b1;
                end
            end
            ENC: if (bus.EncRy) state_d = OUT;
            DEC: if (bus.DecRy) state_d = OUT;
            OUT: if (bus.OutRy) state_d = WRITE;
            WRITE: begin
                if (bus.SerialWriteRy) begin
                    if (blkIdx_q == total_q - BLK_W'(1)) begin
                        done_d    = 1'b1;
                        running_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        blkIdx_d = blkIdx_q + BLK_W'(1);
                        state_d  = READ;
                    end
                end
            end
`ifdef AES_CTRL_TIMEOUT_EN
            ERR:     state_d = ERR;
`else
            ERR:     state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

`ifdef AES_CTRL_TIMEOUT_EN
        // Counter restarts on every state change; READ and IDLE never time out.
        error_d = error_q;
        tmo_d   = '0;
        if (state_d == state_q && state_q inside {KEY, ENC, DEC, OUT, WRITE}) begin
            if (tmo_q == TMO_W'(TMO_CYCLES - 1)) begin
                state_d   = ERR;
                error_d   = 1'b1;
                running_d = 1'b0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif

        en_d = '0;
        case (state_d)
            READ:    en_d = 6'b000001;
            KEY:     en_d = 6'b000010;
            ENC:     en_d = 6'b000100;
            DEC:     en_d = 6'b001000;
            OUT:     en_d = 6'b010000;
            WRITE:   en_d = 6'b100000;
            default: en_d = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            total_q    <= '0;
            blkIdx_q   <= '0;
            keyValid_q <= 1'b0;
            running_q  <= 1'b0;
            rstKey_q   <= 1'b0;
            rstEnc_q   <= 1'b0;
            done_q     <= 1'b0;
            en_q       <= '0;
`ifdef AES_CTRL_TIMEOUT_EN
            error_q    <= 1'b0;
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            total_q    <= total_d;
            blkIdx_q   <= blkIdx_d;
            keyValid_q <= keyValid_d;
            running_q  <= running_d;
            rstKey_q   <= rstKey_d;
            rstEnc_q   <= rstEnc_d;
            done_q     <= done_d;
            en_q       <= en_d;
`ifdef AES_CTRL_TIMEOUT_EN
            error_q    <= error_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign bus.SerialReadEn   = en_q[0];
    assign bus.KeyEn          = en_q[1];
    assign bus.EncEn          = en_q[2];
    assign bus.DecEn          = en_q[3];
    assign bus.OutEn          = en_q[4];
    assign bus.SerialWriteEn  = en_q[5];
    assign bus.RstKey         = rstKey_q;
    assign bus.RstEncryptor   = rstEnc_q;
    assign bus.ProgramRunning = running_q;
    assign bus.BlkIdx         = blkIdx_q;
    assign bus.Done           = done_q;
`ifdef AES_CTRL_TIMEOUT_EN
    assign bus.Error          = error_q;
`else
    assign bus.Error          = 1'b0;
`endif
endmodule

// File: tb/tb_aes_session_controller.sv
// Bench for aes_session_controller: a cycle vector table, hand sequences for reset/timeout corners,
// and randomized multi-session traffic checked against a run-length model of the session rules.
module tb_aes_session_controller;
    localparam int BLK_W = 8;
    localparam int ST_READ = 0, ST_KEY = 1, ST_ENC = 2, ST_DEC = 3, ST_OUT = 4, ST_WRITE = 5;
    localparam int ST_NONE = 6, ST_BAD = 7;

    localparam logic [6:0] R_SR = 7'b0000001, R_SK = 7'b0000010, R_KEY = 7'b0000100, R_ENC = 7'b0001000;
    localparam logic [6:0] R_DEC = 7'b0010000, R_OUT = 7'b0100000, R_SW = 7'b1000000;
    localparam logic [5:0] E_SR = 6'b000001, E_KEY = 6'b000010, E_ENC = 6'b000100;
    localparam logic [5:0] E_DEC = 6'b001000, E_OUT = 6'b010000, E_SW = 6'b100000;
    localparam logic [2:0] P_KEY = 3'b001, P_ENC = 3'b010, P_DONE = 3'b100;

    typedef struct {
        logic       prog;
        logic [7:0] nblk;
        logic       keyNew;
        logic [6:0] rdy;
        logic [5:0] expEn;
        logic [2:0] expPulse;
        logic       expRun;
        logic [7:0] expBlk;
    } vecT;

    typedef struct {
        int stage;
        int dur;
        int blk;
    } runT;

    typedef struct {
        logic       prog;
        logic [7:0] nblk;
        logic       keyNew;
    } sessT;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    vecT  vecs[25];
    runT  expQ[$];
    int   dq[$];
    sessT sess[$];

    aes_session_controller_if #(.BLK_W(BLK_W)) bus();

    aes_session_controller #(
        .BLK_W(BLK_W),
        .TMO_W(16),
        .TMO_CYCLES(16)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic setReadies(input logic [6:0] r);
        bus.SerialReadRy  = r[0];
        bus.SerialKeyRy   = r[1];
        bus.KeyRy         = r[2];
        bus.EncRy         = r[3];
        bus.DecRy         = r[4];
        bus.OutRy         = r[5];
        bus.SerialWriteRy = r[6];
    endtask

    task automatic setParams(input logic prog, input logic [7:0] nblk, input logic keyNew);
        bus.ProgramSelector = prog;
        bus.NumBlocks       = nblk;
        bus.KeyNew          = keyNew;
    endtask

    function automatic logic [5:0] enWord();
        return {bus.SerialWriteEn, bus.OutEn, bus.DecEn, bus.EncEn, bus.KeyEn, bus.SerialReadEn};
    endfunction

    function automatic int outWord();
        return int'({enWord(), bus.RstKey, bus.RstEncryptor, bus.Done, bus.ProgramRunning, bus.Error, bus.BlkIdx});
    endfunction

    function automatic int activeStage();
        logic [5:0] e;
        e = enWord();
        if (e == 6'b0) return ST_NONE;
        if ($countones(e) != 1) return ST_BAD;
        for (int i = 0; i < 6; i++) if (e[i]) return i;
        return ST_BAD;
    endfunction

    task automatic applyReset();
        Rst = 1'b1;
        setReadies(7'b0);
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("resetOutputs", outWord(), 0);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic applyStimulus(input vecT v, input int idx);
        setParams(v.prog, v.nblk, v.keyNew);
        setReadies(v.rdy);
        @(posedge Clk);
        #1;
        checkOutput($sformatf("vec%0d.en", idx), int'(enWord()), int'(v.expEn));
        checkOutput($sformatf("vec%0d.pulse", idx), int'({bus.Done, bus.RstEncryptor, bus.RstKey}), int'(v.expPulse));
        checkOutput($sformatf("vec%0d.run", idx), int'(bus.ProgramRunning), int'(v.expRun));
        checkOutput($sformatf("vec%0d.blk", idx), int'(bus.BlkIdx), int'(v.expBlk));
        @(negedge Clk);
    endtask

    task automatic loadSession(input int idx);
        if (idx < sess.size()) setParams(sess[idx].prog, sess[idx].nblk, sess[idx].keyNew);
        else setParams(1'b0, 8'd1, 1'b0);
    endtask

    task automatic pushRun(input int st, input int blk);
        int d;
        d = $urandom_range(0, 3);
        dq.push_back(d);
        expQ.push_back('{st, d + 1, blk});
    endtask

    initial begin
        int   cur, runStage, runLen, curDelay, sessIdx, cyc, nb, es, eb, expPulse, encCycles, bitIdx;
        bit   started, keyValidModel, found, own;
        sessT p;
        logic [6:0] rdy;

        setParams(1'b1, 8'd1, 1'b1);
        setReadies(7'b0);

        // Cycle table: session (enc, 1 block, new key), then (dec, 2 blocks, key reused), then NumBlocks=0.
        vecs[0]  = '{1'b1, 8'd1, 1'b1, 7'b0,                                E_SR,  3'b0,   1'b0, 8'd0};
        vecs[1]  = '{1'b1, 8'd1, 1'b1, R_SR,                                E_SR,  3'b0,   1'b0, 8'd0};
        vecs[2]  = '{1'b1, 8'd1, 1'b1, R_SK|R_KEY|R_ENC|R_DEC|R_OUT|R_SW,   E_SR,  3'b0,   1'b0, 8'd0};
        vecs[3]  = '{1'b1, 8'd1, 1'b1, R_SR|R_SK,                           E_KEY, P_KEY,  1'b1, 8'd0};
        vecs[4]  = '{1'b1, 8'd1, 1'b1, 7'b0,                                E_KEY, 3'b0,   1'b1, 8'd0};
        vecs[5]  = '{1'b1, 8'd1, 1'b1, R_ENC|R_SR,                          E_KEY, 3'b0,   1'b1, 8'd0};
        vecs[6]  = '{1'b1, 8'd1, 1'b1, R_KEY,                               E_ENC, P_ENC,  1'b1, 8'd0};
        vecs[7]  = '{1'b0, 8'd2, 1'b0, R_ENC,                               E_OUT, 3'b0,   1'b1, 8'd0};
        vecs[8]  = '{1'b0, 8'd2, 1'b0, R_OUT,                               E_SW,  3'b0,   1'b1, 8'd0};
        vecs[9]  = '{1'b0, 8'd2, 1'b0, R_SW,                                6'b0,  P_DONE, 1'b0, 8'd0};
        vecs[10] = '{1'b0, 8'd2, 1'b0, 7'b0,                                E_SR,  3'b0,   1'b0, 8'd0};
        vecs[11] = '{1'b0, 8'd2, 1'b0, R_SR|R_SK,                           E_DEC, P_ENC,  1'b1, 8'd0};
        vecs[12] = '{1'b1, 8'd5, 1'b1, R_DEC|R_ENC,                         E_OUT, 3'b0,   1'b1, 8'd0};
        vecs[13] = '{1'b1, 8'd5, 1'b1, R_OUT,                               E_SW,  3'b0,   1'b1, 8'd0};
        vecs[14] = '{1'b1, 8'd5, 1'b1, R_SW,                                E_SR,  3'b0,   1'b1, 8'd1};
        vecs[15] = '{1'b1, 8'd5, 1'b1, R_SR,                                E_DEC, P_ENC,  1'b1, 8'd1};
        vecs[16] = '{1'b1, 8'd5, 1'b1, R_DEC,                               E_OUT, 3'b0,   1'b1, 8'd1};
        vecs[17] = '{1'b1, 8'd5, 1'b1, R_OUT,                               E_SW,  3'b0,   1'b1, 8'd1};
        vecs[18] = '{1'b1, 8'd0, 1'b0, R_SW,                                6'b0,  P_DONE, 1'b0, 8'd1};
        vecs[19] = '{1'b1, 8'd0, 1'b0, 7'b0,                                E_SR,  3'b0,   1'b0, 8'd0};
        vecs[20] = '{1'b1, 8'd0, 1'b0, R_SR|R_SK,                           E_ENC, P_ENC,  1'b1, 8'd0};
        vecs[21] = '{1'b1, 8'd0, 1'b0, R_ENC,                               E_OUT, 3'b0,   1'b1, 8'd0};
        vecs[22] = '{1'b1, 8'd0, 1'b0, R_OUT,                               E_SW,  3'b0,   1'b1, 8'd0};
        vecs[23] = '{1'b1, 8'd0, 1'b0, R_SW,                                6'b0,  P_DONE, 1'b0, 8'd0};
        vecs[24] = '{1'b1, 8'd0, 1'b0, 7'b0,                                E_SR,  3'b0,   1'b0, 8'd0};

        applyReset();
        for (int i = 0; i < 25; i++) applyStimulus(vecs[i], i);

        // Reset in the middle of block 1 clears everything, including the remembered key.
        setParams(1'b1, 8'd2, 1'b1);
        applyReset();
        setReadies(7'h7F);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge Clk);
            #1;
            if (bus.EncEn && bus.BlkIdx == 8'd1) found = 1;
        end
        checkOutput("midRstReachEnc1", int'(found), 1);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("midRstOutputs", outWord(), 0);
        @(negedge Clk);
        Rst = 1'b0;
        bus.KeyNew = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("midRstThenRead", int'(enWord()), int'(E_SR));
        @(posedge Clk);
        #1;
        checkOutput("midRstKeyAgain", int'(enWord()), int'(E_KEY));
        checkOutput("midRstKeyPulse", int'(bus.RstKey), 1);

        // Encryptor that never finishes.
        setParams(1'b1, 8'd1, 1'b1);
        applyReset();
        setReadies(7'h7F & ~R_ENC);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge Clk);
            #1;
            if (bus.EncEn) found = 1;
        end
        checkOutput("stallReachEnc", int'(found), 1);
`ifdef AES_CTRL_TIMEOUT_EN
        encCycles = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            if (!bus.EncEn) break;
            encCycles++;
        end
        checkOutput("tmoEncCycles", encCycles, 16);
        checkOutput("tmoErrorSet", int'(bus.Error), 1);
        checkOutput("tmoEnablesOff", int'(enWord()), 0);
        checkOutput("tmoNotRunning", int'(bus.ProgramRunning), 0);
        repeat (5) @(posedge Clk);
        #1;
        checkOutput("tmoErrorHeld", int'({bus.Error, enWord()}), 64);
`else
        encCycles = 0;
        repeat (40) @(posedge Clk);
        #1;
        checkOutput("stallStillEnc", int'(enWord()), int'(E_ENC));
        checkOutput("stallNoError", int'(bus.Error), 0);
`endif

        // Random sessions: the model lists each expected stage run (stage, length, block index).
        keyValidModel = 0;
        for (int s = 0; s < 12; s++) begin
            p.prog   = 1'($urandom_range(0, 1));
            p.nblk   = 8'($urandom_range(0, 4));
            p.keyNew = ($urandom_range(0, 3) == 0);
            sess.push_back(p);
            nb = (p.nblk == 0) ? 1 : int'(p.nblk);
            for (int b = 0; b < nb; b++) begin
                pushRun(ST_READ, b);
                if (b == 0 && (p.keyNew || !keyValidModel)) begin
                    pushRun(ST_KEY, b);
                    keyValidModel = 1;
                end
                pushRun(p.prog ? ST_ENC : ST_DEC, b);
                pushRun(ST_OUT, b);
                pushRun(ST_WRITE, b);
            end
            expQ.push_back('{ST_NONE, 1, -1});
        end

        sessIdx = 0;
        loadSession(0);
        applyReset();
        started  = 0;
        runStage = ST_NONE;
        runLen   = 0;
        curDelay = 0;
        cyc      = 0;
        while (expQ.size() > 0 && cyc < 6000) begin
            @(negedge Clk);
            cyc++;
            cur = activeStage();
            if (!started || cur != runStage) begin
                if (started) begin
                    checkOutput("rndRunLength", runLen, expQ[0].dur);
                    expQ.delete(0);
                end
                started  = 1;
                runStage = cur;
                runLen   = 1;
                if (cur == ST_NONE) begin
                    sessIdx++;
                    loadSession(sessIdx);
                end else begin
                    curDelay = (dq.size() > 0) ? dq.pop_front() : 1000;
                end
            end else begin
                runLen++;
            end
            if (expQ.size() == 0) break;

            es = expQ[0].stage;
            eb = expQ[0].blk;
            checkOutput("rndStage", cur, es);
            if (eb >= 0) checkOutput("rndBlkIdx", int'(bus.BlkIdx), eb);
            expPulse = ((es == ST_NONE && runLen == 1) ? 16 : 0)
                     | (((es == ST_ENC || es == ST_DEC) && runLen == 1) ? 8 : 0)
                     | ((es == ST_KEY && runLen == 1) ? 4 : 0)
                     | ((es != ST_NONE && !(es == ST_READ && eb == 0)) ? 2 : 0);
            checkOutput("rndPulses", int'({bus.Done, bus.RstEncryptor, bus.RstKey, bus.ProgramRunning, bus.Error}), expPulse);

            // Only the current stage's ready is meaningful; the others carry random noise.
            rdy = 7'($urandom);
            own = (runLen > curDelay);
            if (cur <= ST_WRITE) begin
                bitIdx = (cur == ST_READ) ? 0 : cur + 1;
                rdy[bitIdx] = own;
                if (cur == ST_READ && eb == 0) rdy[1] = own;
            end
            setReadies(rdy);
            if (cur != ST_NONE) begin
                bus.ProgramSelector = 1'($urandom);
                bus.NumBlocks       = 8'($urandom);
                if (cur != ST_READ) bus.KeyNew = 1'($urandom);
            end
        end
        checkOutput("rndAllRunsSeen", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
